tx_scheduler: RTL and testbench

TX_SCHEDULER -- requirements
Module: tx_scheduler

---
 rtl/tx_scheduler.sv | 82 ++++++++
 tb/tb_tx_scheduler.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/tx_scheduler.sv
// tx_scheduler: word FIFO feeding a byte-wide UART transmitter, two bytes per word.
// HI_FIRST selects which byte of the word goes out first.
module tx_scheduler #(
  parameter int DEPTH    = 4,
  parameter bit HI_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [15:0]              wr_data,
  output logic                     full,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf,
  input  logic                     tx_active,
  input  logic                     tx_done,
  output logic                     tx_dv,
  output logic [7:0]               tx_byte
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [2:0] {IDLE, SEND1, WAIT1, SEND2, WAIT2} state_t;
  state_t r_state, w_next;
  logic [15:0] r_mem [DEPTH];
  logic [15:0] r_hold;
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_count, w_count_nxt;
  logic r_full, r_ovf, r_dv;
  logic [7:0] r_byte, w_first, w_second;
  logic w_push, w_pop, w_send;
  // full is registered, so a pop in the same cycle never rescues a write while full
  assign w_push      = wr_en & ~r_full;
  assign w_pop       = (r_state == IDLE) & (r_count != '0);
  assign w_count_nxt = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
  assign w_send      = ((r_state == SEND1) | (r_state == SEND2)) & ~tx_active;
  assign w_first     = HI_FIRST ? r_hold[15:8] : r_hold[7:0];
  assign w_second    = HI_FIRST ? r_hold[7:0]  : r_hold[15:8];
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = w_pop ? SEND1 : IDLE;
      SEND1:   w_next = tx_active ? SEND1 : WAIT1;
      WAIT1:   w_next = tx_done ? SEND2 : WAIT1;
      SEND2:   w_next = tx_active ? SEND2 : WAIT2;
      WAIT2:   w_next = tx_done ? IDLE : WAIT2;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= wr_data;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_ovf   <= 1'b0;
      r_hold  <= '0;
      r_dv    <= 1'b0;
      r_byte  <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop) begin
        r_rp   <= r_rp + AW'(1);
        r_hold <= r_mem[r_rp];
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == (AW+1)'(DEPTH));
      if (wr_en && r_full) r_ovf <= 1'b1;
      r_dv <= w_send;
      if (w_send) r_byte <= (r_state == SEND1) ? w_first : w_second;
    end
  end
  assign full    = r_full;
  assign count   = r_count;
  assign ovf     = r_ovf;
  assign busy    = (r_state != IDLE) | (r_count != '0);
  assign tx_dv   = r_dv;
  assign tx_byte = r_byte;
endmodule

// File: tb/tb_tx_scheduler.sv
// tb_tx_scheduler: scoreboard bench; two DUTs (HI_FIRST=1 and 0) share stimulus and a UART stand-in.
// The reference model tracks queued words and the in-flight word as plain queues.
module tb_tx_scheduler;
  localparam int DEPTH = 4;
  logic clk = 1'b0, rst = 1'b1, wr_en = 1'b0, tx_done = 1'b0;
  logic hold_active = 1'b0, uart_busy = 1'b0, tx_active;
  logic [15:0] wr_data = '0;
  logic full_h, busy_h, ovf_h, dv_h, full_l, busy_l, ovf_l, dv_l;
  logic [2:0] count_h, count_l;
  logic [7:0] byte_h, byte_l;
  assign tx_active = uart_busy | hold_active;
  always #5 clk = ~clk;
  tx_scheduler #(.DEPTH(DEPTH), .HI_FIRST(1'b1)) u_hi (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full_h), .busy(busy_h),
    .count(count_h), .ovf(ovf_h), .tx_active(tx_active), .tx_done(tx_done), .tx_dv(dv_h), .tx_byte(byte_h));
  tx_scheduler #(.DEPTH(DEPTH), .HI_FIRST(1'b0)) u_lo (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full_l), .busy(busy_l),
    .count(count_l), .ovf(ovf_l), .tx_active(tx_active), .tx_done(tx_done), .tx_dv(dv_l), .tx_byte(byte_l));
  typedef struct {logic [15:0] w; int idx; int cyc;} exp_t;
  exp_t sb[$];
  logic [15:0] q[$];
  logic [15:0] cur;
  bit inflight, waiting, ovf_m, uart_rand;
  int bi, cyc, errors, checks, uart_dly = 10, ucnt;
  function automatic logic [7:0] sel(logic [15:0] w, int idx, bit hi);
    return ((idx == 0) == hi) ? w[15:8] : w[7:0];
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // reference model: one step per edge, using the values present before the edge
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete(); sb.delete();
      inflight = 0; waiting = 0; ovf_m = 0; bi = 0;
    end else begin
      bit full_pre;
      cyc++;
      full_pre = (q.size() == DEPTH);
      if (inflight) begin
        if (!waiting) begin
          if (!tx_active) begin sb.push_back('{cur, bi, cyc}); waiting = 1; end
        end else if (tx_done) begin
          waiting = 0;
          if (bi == 1) inflight = 0; else bi = 1;
        end
      end else if (q.size() > 0) begin
        cur = q.pop_front(); inflight = 1; waiting = 0; bi = 0;
      end
      if (wr_en) begin
        if (full_pre) ovf_m = 1; else q.push_back(wr_data);
      end
    end
  end
  always @(negedge clk) if (rst) begin
    bit exp_dv;
    exp_dv = (sb.size() > 0) && (sb[0].cyc == cyc);
    chk("count", 32'(count_h), 32'(q.size()));
    chk("count_lo", 32'(count_l), 32'(q.size()));
    chk("full", 32'(full_h), 32'(q.size() == DEPTH));
    chk("busy", 32'(busy_h), 32'(inflight || q.size() > 0));
    chk("ovf", 32'(ovf_h), 32'(ovf_m));
    chk("tx_dv", 32'(dv_h), 32'(exp_dv));
    chk("tx_dv_lo", 32'(dv_l), 32'(exp_dv));
    if (exp_dv) begin
      exp_t e;
      e = sb.pop_front();
      chk("tx_byte", 32'(byte_h), 32'(sel(e.w, e.idx, 1'b1)));
      chk("tx_byte_lo", 32'(byte_l), 32'(sel(e.w, e.idx, 1'b0)));
    end
  end
  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      uart_busy = 0; tx_done = 0; ucnt = 0;
    end else begin
      tx_done = 0;
      if (dv_h) begin
        uart_busy = 1;
        ucnt = uart_rand ? int'($urandom_range(1, 12)) : uart_dly;
      end else if (uart_busy) begin
        if (ucnt <= 1) begin tx_done = 1; uart_busy = 0; end
        else ucnt--;
      end
    end
  end
  task automatic wait_idle(int max);
    int k = 0;
    while ((inflight || q.size() > 0 || sb.size() > 0) && k < max) begin
      @(negedge clk); k++;
    end
    chk("idle_timeout", 32'(k < max), 32'd1);
  endtask
  task automatic zero_checks();
    chk("rst_dv", 32'({dv_h, dv_l}), 0);
    chk("rst_count", 32'({count_h, count_l}), 0);
    chk("rst_busy", 32'({busy_h, busy_l}), 0);
    chk("rst_full_ovf", 32'({full_h, ovf_h}), 0);
    chk("rst_byte", 32'({byte_h, byte_l}), 0);
  endtask
  task automatic do_reset(bit wr, logic [15:0] d);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 zero_checks();
    @(negedge clk);
    rst = 1'b1; wr_en = wr; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask
  task automatic write(logic [15:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_data = d;
  endtask
  initial begin
    #1 rst = 1'b0;
    #2 zero_checks();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    write(16'hA55A);
    @(negedge clk) wr_en = 1'b0;
    wait_idle(200);
    do_reset(0, 0);
    hold_active = 1'b1;
    for (int i = 1; i <= 6; i++) write(16'(i));
    @(negedge clk) wr_en = 1'b0;
    #1 chk("ovf_set", 32'(ovf_h), 1);
    chk("full_set", 32'(full_h), 1);
    hold_active = 1'b0;
    wait_idle(500);
    do_reset(0, 0);
    uart_rand = 1;
    for (int n = 0; n < 10;) begin
      @(negedge clk);
      if (q.size() < DEPTH) begin wr_en = 1'b1; wr_data = 16'($urandom); n++; end
      else wr_en = 1'b0;
    end
    @(negedge clk) wr_en = 1'b0;
    wait_idle(1000);
    chk("ovf_wrap", 32'(ovf_h), 0);
    hold_active = 1'b1;
    write(16'h1111); write(16'h2222); write(16'h3333);
    @(negedge clk) wr_en = 1'b0;
    hold_active = 1'b0;
    for (int k = 0; k < 200 && !(!inflight && q.size() == 2); k++) @(negedge clk);
    chk("collide_setup", 32'(!inflight && q.size() == 2), 1);
    wr_en = 1'b1; wr_data = 16'h4444;
    @(negedge clk) wr_en = 1'b0;
    #1 chk("collide_count", 32'(count_h), 2);
    wait_idle(500);
    uart_rand = 0; uart_dly = 30;
    write(16'hBEEF); write(16'h0102); write(16'h0304);
    @(negedge clk) wr_en = 1'b0;
    for (int k = 0; k < 100 && !(inflight && waiting && bi == 0); k++) @(negedge clk);
    chk("wait1_reached", 32'(inflight && waiting && bi == 0 && q.size() == 2), 1);
    do_reset(0, 0);
    repeat (40) @(negedge clk);
    uart_dly = 10;
    do_reset(1, 16'h3C5A);
    wait_idle(200);
    hold_active = 1'b1;
    write(16'h12AB);
    @(negedge clk) wr_en = 1'b0;
    repeat (4) @(negedge clk);
    hold_active = 1'b0;
    wait_idle(200);
    uart_rand = 1;
    repeat (400) begin
      @(negedge clk);
      wr_en = ($urandom_range(0, 2) == 0);
      wr_data = 16'($urandom);
      hold_active = ($urandom_range(0, 7) == 0);
    end
    @(negedge clk);
    wr_en = 1'b0; hold_active = 1'b0;
    wait_idle(3000);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end
endmodule
